count_seq_ctrl: RTL and testbench

- Parametrised counting sequencer; successor to the fixed 2-bit Initial/Count/Done/Change controller.
- Integrates the up-counter and a programmable terminal count.
- Adds a start/busy handshake, an abort, auto-restart mode, and an NCH-way channel pointer advanced on change requests.
- Sits between the measurement/timing datapath and the top-level control.

---
 rtl/count_seq_ctrl_pkg.sv | 23 ++
 rtl/count_seq_ctrl_if.sv | 50 +++++
 rtl/count_seq_ctrl_seq_counter.sv | 32 +++
 rtl/count_seq_ctrl.sv | 117 +++++++++++
 tb/tb_count_seq_ctrl.sv | 191 +++++++++++++++++++
 5 files changed

// File: rtl/count_seq_ctrl_pkg.sv
// count_seq_pkg: shared definitions for the counting sequencer slice.
//   - default counter width and channel count
//   - state_t encodings (3-bit, kept as plain constants for legacy tools)
//   - ch_width() helper used to size the channel pointer
package count_seq_pkg;

  localparam int DEF_CNT_W = 8;
  localparam int DEF_NCH   = 4;

  typedef logic [2:0] state_t;

  localparam state_t S_IDLE   = 3'd0;
  localparam state_t S_INIT   = 3'd1;
  localparam state_t S_COUNT  = 3'd2;
  localparam state_t S_DONE   = 3'd3;
  localparam state_t S_CHANGE = 3'd4;

  // Channel pointer width; a single-channel build would still need one bit.
  function automatic int ch_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/count_seq_ctrl_if.sv
// count_seq_ctrl_if: control/status bundle between the top-level controller
// (master) and the counting sequencer (slave).
//   master -> slave : start, stop, auto, limit[CNT_W], ch
//   slave -> master : cnt[CNT_W], chan[CH_W], rst_o, done, chout, busy
//                     start_err (only when COUNT_SEQ_START_ERR_EN is defined)
interface count_seq_ctrl_if #(
  parameter int CNT_W = 8,
  parameter int NCH   = 4
);
  import count_seq_pkg::*;

  localparam int CH_W = ch_width(NCH);

  logic             start;
  logic             stop;
  logic             auto;
  logic [CNT_W-1:0] limit;
  logic             ch;
  logic [CNT_W-1:0] cnt;
  logic [CH_W-1:0]  chan;
  logic             rst_o;
  logic             done;
  logic             chout;
  logic             busy;

`ifdef COUNT_SEQ_START_ERR_EN
  logic             start_err;

  modport master (
    output start, stop, auto, limit, ch,
    input  cnt, chan, rst_o, done, chout, busy, start_err
  );

  modport slave (
    input  start, stop, auto, limit, ch,
    output cnt, chan, rst_o, done, chout, busy, start_err
  );
`else
  modport master (
    output start, stop, auto, limit, ch,
    input  cnt, chan, rst_o, done, chout, busy
  );

  modport slave (
    input  start, stop, auto, limit, ch,
    output cnt, chan, rst_o, done, chout, busy
  );
`endif

endinterface

// File: rtl/count_seq_ctrl_seq_counter.sv
// seq_counter: up-counter with synchronous clear and count enable, plus a
// combinational compare against a terminal value.
//   clk, reset : clock and asynchronous active-high reset (cnt -> 0)
//   clr        : synchronous clear, dominates en
//   en         : increment by one
//   lim        : terminal value for the compare
//   cnt        : current count
//   term       : cnt == lim
module seq_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  input  logic [CNT_W-1:0] lim,
  output logic [CNT_W-1:0] cnt,
  output logic             term
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      cnt <= '0;
    else if (clr)
      cnt <= '0;
    else if (en)
      cnt <= cnt + 1'b1;
  end

  assign term = (cnt == lim);

endmodule

// File: rtl/count_seq_ctrl.sv
// count_seq_ctrl: parametrised counting sequencer.
// A start in IDLE runs INIT (clear counter, latch limit), then COUNT from 0
// up to the latched limit, then DONE (or CHANGE if a change request is seen
// on the terminal count, which also advances the channel pointer). Auto mode
// loops back to INIT; stop aborts to IDLE from anywhere.
//   clk, reset : clock, asynchronous active-high reset
//   bus.start  : begin a run (IDLE only)
//   bus.stop   : synchronous abort, highest priority
//   bus.auto   : restart after DONE/CHANGE
//   bus.limit  : terminal count, latched in INIT
//   bus.ch     : change request, sampled on the terminal count
//   bus.cnt    : current count        bus.chan  : current channel
//   bus.rst_o  : high in INIT         bus.done  : high in DONE/CHANGE
//   bus.chout  : high in CHANGE       bus.busy  : high outside IDLE
// Optional: define COUNT_SEQ_START_ERR_EN to add bus.start_err, a sticky flag
// raised by a start request while busy and cleared by the next accepted start.
module count_seq_ctrl
  import count_seq_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W,
  parameter int NCH   = DEF_NCH
) (
  input  logic               clk,
  input  logic               reset,
  count_seq_ctrl_if.slave    bus
);

  localparam int CH_W = ch_width(NCH);
  localparam logic [CH_W-1:0] CH_LAST = CH_W'(NCH - 1);

  state_t           state;
  state_t           nxt;
  logic [CNT_W-1:0] lim_q;
  logic [CH_W-1:0]  chan_q;
  logic [CNT_W-1:0] cnt_w;
  logic             term;
  logic             cnt_clr;
  logic             cnt_en;

  // Stop overrides every transition, including the terminal decision.
  always_comb begin
    nxt = state;
    if (bus.stop) begin
      nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE:           if (bus.start) nxt = S_INIT;
        S_INIT:           nxt = S_COUNT;
        S_COUNT:          if (term) nxt = bus.ch ? S_CHANGE : S_DONE;
        S_DONE, S_CHANGE: nxt = bus.auto ? S_INIT : S_IDLE;
        default:          nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      state <= S_IDLE;
    else
      state <= nxt;
  end

  // An aborted cycle leaves the counter, limit and channel untouched.
  assign cnt_clr = (state == S_INIT) && !bus.stop;
  assign cnt_en  = (state == S_COUNT) && !term && !bus.stop;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      lim_q <= '0;
    else if (cnt_clr)
      lim_q <= bus.limit;
  end

  seq_counter #(
    .CNT_W (CNT_W)
  ) u_counter (
    .clk   (clk),
    .reset (reset),
    .clr   (cnt_clr),
    .en    (cnt_en),
    .lim   (lim_q),
    .cnt   (cnt_w),
    .term  (term)
  );

  // Channel pointer wraps explicitly so non-power-of-two NCH works.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      chan_q <= '0;
    else if ((state == S_CHANGE) && !bus.stop)
      chan_q <= (chan_q == CH_LAST) ? '0 : chan_q + 1'b1;
  end

`ifdef COUNT_SEQ_START_ERR_EN
  logic start_err_q;

  // Clear on an accepted start takes precedence over the busy-start set.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      start_err_q <= 1'b0;
    else if ((state == S_IDLE) && bus.start && !bus.stop)
      start_err_q <= 1'b0;
    else if ((state != S_IDLE) && bus.start && !bus.stop)
      start_err_q <= 1'b1;
  end

  assign bus.start_err = start_err_q;
`endif

  assign bus.cnt   = cnt_w;
  assign bus.chan  = chan_q;
  assign bus.rst_o = (state == S_INIT);
  assign bus.done  = (state == S_DONE) || (state == S_CHANGE);
  assign bus.chout = (state == S_CHANGE);
  assign bus.busy  = (state != S_IDLE);

endmodule

// File: tb/tb_count_seq_ctrl.sv
// tb_count_seq_ctrl: directed self-checking bench for count_seq_ctrl
// (CNT_W=8, NCH=4). Inputs change 1 time unit after a rising edge and
// outputs are sampled at the same point, so each applyStimulus call shows
// the result of exactly one clock edge.
module tb_count_seq_ctrl;

  logic clk;
  logic reset;
  int   total;
  int   bad;

  count_seq_ctrl_if #(.CNT_W(8), .NCH(4)) bus ();

  count_seq_ctrl #(
    .CNT_W (8),
    .NCH   (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic s, input logic p, input logic a,
                               input logic [7:0] l, input logic c);
    bus.start = s;
    bus.stop  = p;
    bus.auto  = a;
    bus.limit = l;
    bus.ch    = c;
    tick();
  endtask

  task automatic checkOutput(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic checkState(input string tag, input int r, input int d,
                            input int co, input int b);
    checkOutput({tag, ".rst_o"}, int'(bus.rst_o), r);
    checkOutput({tag, ".done"},  int'(bus.done),  d);
    checkOutput({tag, ".chout"}, int'(bus.chout), co);
    checkOutput({tag, ".busy"},  int'(bus.busy),  b);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b1;
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    bus.auto  = 1'b0;
    bus.limit = 8'd0;
    bus.ch    = 1'b0;
    tick();
    tick();
    checkState("reset", 0, 0, 0, 0);
    checkOutput("reset.cnt",  int'(bus.cnt),  0);
    checkOutput("reset.chan", int'(bus.chan), 0);
`ifdef COUNT_SEQ_START_ERR_EN
    checkOutput("reset.start_err", int'(bus.start_err), 0);
`endif
    reset = 1'b0;
    tick();

    // Basic run, limit=3; limit changed to 1 after INIT must be ignored
    $display("[TB] basic run");
    applyStimulus(1, 0, 0, 8'd3, 0);
    checkState("basic.init", 1, 0, 0, 1);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 0, 0, (i == 0) ? 8'd3 : 8'd1, 0);
      checkOutput("basic.cnt", int'(bus.cnt), i);
      checkState("basic.count", 0, 0, 0, 1);
    end
    applyStimulus(0, 0, 0, 8'd1, 0);
    checkState("basic.done", 0, 1, 0, 1);
    checkOutput("basic.done_cnt", int'(bus.cnt), 3);
    applyStimulus(0, 0, 0, 8'd1, 0);
    checkState("basic.idle", 0, 0, 0, 0);

    // Four change runs: channel 0 -> 1 -> 2 -> 3 -> 0
    $display("[TB] change runs");
    for (int r = 0; r < 4; r++) begin
      applyStimulus(1, 0, 0, 8'd2, 1);
      checkState("chg.init", 1, 0, 0, 1);
      for (int k = 0; k < 3; k++) begin
        applyStimulus(0, 0, 0, 8'd2, 1);
        checkOutput("chg.cnt", int'(bus.cnt), k);
      end
      applyStimulus(0, 0, 0, 8'd2, 1);
      checkState("chg.change", 0, 1, 1, 1);
      checkOutput("chg.chan_old", int'(bus.chan), r);
      applyStimulus(0, 0, 0, 8'd2, 0);
      checkState("chg.idle", 0, 0, 0, 0);
      checkOutput("chg.chan_new", int'(bus.chan), (r + 1) % 4);
    end

    // Auto mode with limit=0: INIT, COUNT, DONE repeating
    $display("[TB] auto mode");
    for (int p = 0; p < 3; p++) begin
      applyStimulus(p == 0, 0, 1, 8'd0, 0);
      checkState("auto.init", 1, 0, 0, 1);
      applyStimulus(0, 0, 1, 8'd0, 0);
      checkState("auto.count", 0, 0, 0, 1);
      checkOutput("auto.cnt", int'(bus.cnt), 0);
      applyStimulus(0, 0, 1, 8'd0, 0);
      checkState("auto.done", 0, 1, 0, 1);
    end
    applyStimulus(0, 0, 0, 8'd0, 0);
    checkState("auto.idle", 0, 0, 0, 0);

    // Abort on the terminal count with a change request pending
    $display("[TB] abort");
    applyStimulus(1, 0, 0, 8'd2, 1);
    for (int k = 0; k < 3; k++) begin
      applyStimulus(0, 0, 0, 8'd2, 1);
      checkOutput("abort.cnt", int'(bus.cnt), k);
    end
    applyStimulus(0, 1, 0, 8'd2, 1);
    checkState("abort.idle", 0, 0, 0, 0);
    checkOutput("abort.chan", int'(bus.chan), 0);
    checkOutput("abort.cnt_hold", int'(bus.cnt), 2);
    applyStimulus(0, 0, 0, 8'd2, 1);
    checkState("abort.after", 0, 0, 0, 0);
    applyStimulus(1, 1, 0, 8'd2, 0);
    checkState("start_stop", 0, 0, 0, 0);

    // Move to channel 1, then reset in the middle of a count
    $display("[TB] async reset");
    applyStimulus(1, 0, 0, 8'd0, 1);
    applyStimulus(0, 0, 0, 8'd0, 1);
    applyStimulus(0, 0, 0, 8'd0, 1);
    checkState("pre_rst.change", 0, 1, 1, 1);
    applyStimulus(0, 0, 0, 8'd0, 0);
    checkOutput("pre_rst.chan", int'(bus.chan), 1);
    applyStimulus(1, 0, 0, 8'd9, 0);
    for (int k = 0; k < 6; k++) applyStimulus(0, 0, 0, 8'd9, 0);
    checkOutput("pre_rst.cnt", int'(bus.cnt), 5);
    reset = 1'b1;
    #2;
    checkOutput("rst.cnt",  int'(bus.cnt),  0);
    checkOutput("rst.busy", int'(bus.busy), 0);
    checkOutput("rst.chan", int'(bus.chan), 0);
    bus.start = 1'b1;
    tick();
    reset = 1'b0;
    checkOutput("rst_start.busy", int'(bus.busy), 0);
    applyStimulus(0, 0, 0, 8'd0, 0);
    checkState("rst_start.idle", 0, 0, 0, 0);

    // Maximum limit: counts 0..255 without wrapping; busy start midway
    $display("[TB] max limit");
    applyStimulus(1, 0, 0, 8'd255, 0);
    checkState("max.init", 1, 0, 0, 1);
    for (int i = 0; i < 256; i++) begin
      applyStimulus(i == 10, 0, 0, (i == 0) ? 8'd255 : 8'd0, 0);
      checkOutput("max.cnt", int'(bus.cnt), i);
    end
    applyStimulus(0, 0, 0, 8'd0, 0);
    checkState("max.done", 0, 1, 0, 1);
    checkOutput("max.done_cnt", int'(bus.cnt), 255);
    applyStimulus(0, 0, 0, 8'd0, 0);
    checkState("max.idle", 0, 0, 0, 0);
`ifdef COUNT_SEQ_START_ERR_EN
    checkOutput("start_err.set", int'(bus.start_err), 1);
`endif
    applyStimulus(1, 0, 0, 8'd4, 0);
    checkState("restart.init", 1, 0, 0, 1);
`ifdef COUNT_SEQ_START_ERR_EN
    checkOutput("start_err.clr", int'(bus.start_err), 0);
`endif
    applyStimulus(0, 1, 0, 8'd4, 0);
    checkState("init_stop.idle", 0, 0, 0, 0);
    checkOutput("init_stop.cnt", int'(bus.cnt), 255);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
